acc_threshold_pack: RTL and testbench

//  Downstream stage of the 4-input adder tree. Accumulates the registered adder-tree partial sums

---
 rtl/acc_threshold_pack.sv | 213 +++++++++++++++++++++
 tb/tb_acc_threshold_pack.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_threshold_pack.sv
// Accumulates adder-tree partial sums per neuron, binarizes against a folded BN threshold, packs bits LSB-first.
// Latency: last beat of the word-completing neuron -> out_valid the next cycle when the output slot is free.
// Backpressure: in_ready drops only while a finished word waits in HOLD for the occupied output slot.
module acc_threshold_pack #(
    parameter int WIDTH_IN = 8,
    parameter int ACC_W    = WIDTH_IN + 16,
    parameter int PASS_W   = 8,
    parameter int PACK     = 32,
    localparam int PS_W    = WIDTH_IN + 11,
    localparam int CNT_W   = $clog2(PACK) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PS_W-1:0]   in_psum,
    input  logic              flush,
    input  logic [PASS_W-1:0] cfg_passes,
    input  logic [ACC_W-1:0]  cfg_thresh,
    input  logic              cfg_flip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK-1:0]   out_bits,
    output logic [CNT_W-1:0]  out_count,
    output logic              sat_flag
);

    typedef enum logic {S_ACCUM = 1'b0, S_HOLD = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [PASS_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [PACK-1:0]    r_pack;
    logic [PACK-1:0]    r_hold_bits;
    logic [CNT_W-1:0]   r_hold_count;
    logic               r_out_valid;
    logic [PACK-1:0]    r_out_bits;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_sat;

    logic [PASS_W-1:0]  w_passes;
    logic               w_beat;
    logic               w_last;
    logic [ACC_W:0]     w_psum_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_bit;
    logic [PACK-1:0]    w_pack_set;
    logic               w_word_done;
    logic               w_flush_ok;
    logic               w_emit;
    logic [PACK-1:0]    w_emit_bits;
    logic [CNT_W-1:0]   w_emit_count;
    logic               w_slot_free;
    logic               w_load_emit;
    logic               w_load_hold;
    logic               w_latch_hold;

    // HOLD blocks input purely from state so in_ready has no combinational path from out_ready.
    assign in_ready = (r_state == S_ACCUM);

    assign w_passes    = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
    assign w_beat      = in_valid & in_ready;
    assign w_last      = w_beat && (r_beat_cnt == (w_passes - PASS_W'(1)));

    // One guard bit above the accumulator: overflow shows up as the top two bits disagreeing.
    assign w_psum_ext  = {{(ACC_W + 1 - PS_W){in_psum[PS_W-1]}}, in_psum};
    assign w_sum       = {r_acc[ACC_W-1], r_acc} + w_psum_ext;
    assign w_ovf       = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_nxt   = !w_ovf        ? w_sum[ACC_W-1:0] :
                         w_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};
    assign w_bit       = ($signed(w_acc_nxt) >= $signed(cfg_thresh)) ^ cfg_flip;

    assign w_word_done = w_last && (r_bit_cnt == CNT_W'(PACK - 1));
    assign w_flush_ok  = flush && (r_state == S_ACCUM) && !w_beat &&
                         (r_beat_cnt == '0) && (r_bit_cnt != '0);
    assign w_emit       = w_word_done | w_flush_ok;
    assign w_emit_bits  = w_word_done ? w_pack_set : r_pack;
    assign w_emit_count = w_word_done ? CNT_W'(PACK) : r_bit_cnt;
    assign w_slot_free  = !r_out_valid | out_ready;

    // Insert the freshly decided neuron bit at the current pack position.
    always_comb begin
        w_pack_set = r_pack;
        w_pack_set[r_bit_cnt[CNT_W-2:0]] = w_bit;
    end

    // Next state and slot-load decisions; a finished word goes straight to the slot if it is free.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_emit  = 1'b0;
        w_load_hold  = 1'b0;
        w_latch_hold = 1'b0;
        case (r_state)
            S_ACCUM: begin
                if (w_emit) begin
                    if (w_slot_free) begin
                        w_load_emit = 1'b1;
                    end else begin
                        w_latch_hold = 1'b1;
                        w_state_nxt  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_load_hold = 1'b1;
                    w_state_nxt = S_ACCUM;
                end
            end
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACCUM;
        end else if (clear) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulator, beat/bit counters and pack register; pack clears once its word is handed to slot or HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_bit_cnt  <= '0;
            r_pack     <= '0;
            r_sat      <= 1'b0;
        end else if (clear) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_bit_cnt  <= '0;
            r_pack     <= '0;
            r_sat      <= 1'b0;
        end else begin
            if (w_beat && w_ovf) begin
                r_sat <= 1'b1;
            end
            if (w_beat) begin
                if (w_last) begin
                    r_acc      <= '0;
                    r_beat_cnt <= '0;
                    if (w_word_done) begin
                        r_bit_cnt <= '0;
                        r_pack    <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        r_pack    <= w_pack_set;
                    end
                end else begin
                    r_acc      <= w_acc_nxt;
                    r_beat_cnt <= r_beat_cnt + PASS_W'(1);
                end
            end else if (w_flush_ok) begin
                r_bit_cnt <= '0;
                r_pack    <= '0;
            end
        end
    end

    // Word waiting for the slot while in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_bits  <= '0;
            r_hold_count <= '0;
        end else if (clear) begin
            r_hold_bits  <= '0;
            r_hold_count <= '0;
        end else if (w_latch_hold) begin
            r_hold_bits  <= w_emit_bits;
            r_hold_count <= w_emit_count;
        end
    end

    // Output slot: reload wins over transfer; contents hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_count <= '0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_count <= '0;
        end else if (w_load_emit) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= w_emit_bits;
            r_out_count <= w_emit_count;
        end else if (w_load_hold) begin
            r_out_valid <= 1'b1;
            r_out_bits  <= r_hold_bits;
            r_out_count <= r_hold_count;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bits  = r_out_bits;
    assign out_count = r_out_count;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_acc_threshold_pack.sv
// Bench for acc_threshold_pack at WIDTH_IN=9, ACC_W=20, PACK=8; words checked against a scoreboard queue.
// Latency: expected words are queued when stimulus is driven and compared on each output transfer.
// Backpressure: out_ready is held low in dedicated scenarios to exercise the slot and HOLD paths.
module tb_acc_threshold_pack;

    localparam int WIDTH_IN = 9;
    localparam int ACC_W    = 20;
    localparam int PASS_W   = 8;
    localparam int PACK     = 8;
    localparam int PS_W     = WIDTH_IN + 11;
    localparam int CNT_W    = $clog2(PACK) + 1;

    typedef struct {
        logic [PACK-1:0]  bits;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PS_W-1:0]   in_psum;
    logic              flush;
    logic [PASS_W-1:0] cfg_passes;
    logic [ACC_W-1:0]  cfg_thresh;
    logic              cfg_flip;
    logic              out_valid;
    logic              out_ready;
    logic [PACK-1:0]   out_bits;
    logic [CNT_W-1:0]  out_count;
    logic              sat_flag;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    acc_threshold_pack #(
        .WIDTH_IN(WIDTH_IN),
        .ACC_W(ACC_W),
        .PASS_W(PASS_W),
        .PACK(PACK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_psum(in_psum),
        .flush(flush),
        .cfg_passes(cfg_passes),
        .cfg_thresh(cfg_thresh),
        .cfg_flip(cfg_flip),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits(out_bits),
        .out_count(out_count),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard: every transfer must match the oldest expected word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word got bits=%h count=%0d required no word", out_bits, out_count);
            end else begin
                e = sb.pop_front();
                if (out_bits !== e.bits || out_count !== e.cnt) begin
                    failures++;
                    $display("FAIL word got bits=%h count=%0d required bits=%h count=%0d",
                             out_bits, out_count, e.bits, e.cnt);
                end
            end
        end
    end

    task automatic push_exp(input logic [PACK-1:0] b, input int c);
        exp_t e;
        e.bits = b;
        e.cnt  = c[CNT_W-1:0];
        sb.push_back(e);
    endtask

    task automatic cfg(input int p, input int th, input logic f);
        cfg_passes = p[PASS_W-1:0];
        cfg_thresh = th[ACC_W-1:0];
        cfg_flip   = f;
    endtask

    // One accepted beat; waits (bounded) for in_ready.
    task automatic send(input int v);
        int n = 0;
        in_valid = 1'b1;
        in_psum  = v[PS_W-1:0];
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_accept got in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_psum = '0; flush = 1'b0;
        out_ready = 1'b0;
        cfg(1, 0, 1'b0);
        #23;
        checks++;
        if (out_valid !== 1'b0 || out_bits !== '0 || out_count !== '0) begin
            failures++;
            $display("FAIL reset_out got v=%b bits=%h cnt=%0d required 0/00/0", out_valid, out_bits, out_count);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_sat got %b required 0", sat_flag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_p1_pack();
        int ps[8] = '{5, -3, 0, -1, 7, -8, 2, -2};
        cfg(1, 0, 1'b0);
        out_ready = 1'b1;
        push_exp(8'h55, 8);
        for (int i = 0; i < 8; i++) begin
            send(ps[i]);
            if (i == 6) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL early_valid got %b required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency got out_valid=%b required 1", out_valid);
        end
        wait_drain();
    endtask

    task automatic test_flip_zero_passes();
        int ps[8] = '{5, -3, 0, -1, 7, -8, 2, -2};
        cfg(0, 0, 1'b1);
        push_exp(8'hAA, 8);
        for (int i = 0; i < 8; i++) send(ps[i]);
        wait_drain();
    endtask

    task automatic test_passes();
        int ps[8] = '{30, 30, 30, 9, 30, 30, 30, 10};
        cfg(4, 100, 1'b0);
        push_exp(8'h02, 2);
        for (int i = 0; i < 8; i++) send(ps[i]);
        flush_pulse();
        wait_drain();
    endtask

    task automatic test_flush();
        cfg(1, 0, 1'b0);
        flush_pulse();
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got out_valid=%b required 0", out_valid);
        end
        push_exp(8'h05, 3);
        send(1); send(-1); send(1);
        flush_pulse();
        wait_drain();
        flush_pulse();
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_after_emit got out_valid=%b required 0", out_valid);
        end
        cfg(2, 0, 1'b0);
        send(5);
        flush_pulse();
        idle(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_mid_neuron got out_valid=%b required 0", out_valid);
        end
        push_exp(8'h00, 1);
        send(-10);
        flush_pulse();
        wait_drain();
    endtask

    task automatic test_saturation();
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_before got %b required 0", sat_flag);
        end
        cfg(3, 524287, 1'b0);
        push_exp(8'h01, 1);
        send(262144); send(262144); send(262144);
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_set got %b required 1", sat_flag);
        end
        flush_pulse();
        wait_drain();
        checks++;
        if (sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_sticky got %b required 1", sat_flag);
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if (sat_flag !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear got %b required 0", sat_flag);
        end
    endtask

    task automatic test_back_to_back();
        int ps[16] = '{5, -3, 0, -1, 7, -8, 2, -2, -1, 1, 1, 1, 1, 1, 1, 1};
        cfg(1, 0, 1'b0);
        out_ready = 1'b0;
        push_exp(8'h55, 8);
        push_exp(8'hFE, 8);
        for (int i = 0; i < 16; i++) send(ps[i]);
        idle(2);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_in_ready got %b required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_bits !== 8'h55) begin
            failures++;
            $display("FAIL slot_hold got v=%b bits=%h required 1/55", out_valid, out_bits);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL release_same_cycle got in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_next_cycle got in_ready=%b required 1", in_ready);
        end
        wait_drain();
    endtask

    task automatic test_reset_midword();
        int ps[8] = '{-1, -1, -1, -1, 1, 1, 1, 1};
        cfg(1, 0, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1);
        send(1); send(1); send(1);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid got %b required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_bits !== '0 || out_count !== '0) begin
            failures++;
            $display("FAIL async_reset got v=%b bits=%h cnt=%0d required 0/00/0", out_valid, out_bits, out_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_exp(8'hF0, 8);
        for (int i = 0; i < 8; i++) send(ps[i]);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_p1_pack();
        test_flip_zero_passes();
        test_passes();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_reset_midword();
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover got pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
